operand_accumulator: RTL and testbench

//  Sequential front end for the 16-bit ripple adder (SixTeenBitFullAdder).

---
 rtl/operand_accumulator_if.sv | 27 ++
 rtl/operand_accumulator.sv | 93 +++++++++
 tb/tb_operand_accumulator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/operand_accumulator_if.sv
// Operand-in / result-out handshake bundle for operand_accumulator.
// master drives operands and result acceptance; slave is the accumulator.
interface operand_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] count_in;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             busy;

    modport master (
        output start, count_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, busy
    );

    modport slave (
        input  start, count_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_carry, busy
    );
endinterface

// File: rtl/operand_accumulator.sv
// Accumulates a counted burst of unsigned operands and returns sum plus sticky carry.
// Latency: result valid the cycle after the last operand; in_ready/out_valid decode from state only.
module operand_accumulator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_rem;

    logic             w_load;
    logic             w_acc_en;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Adder: A = accumulator, B = operand, carry-in tied low.
    assign {w_cout, w_sum} = {1'b0, r_acc} + {1'b0, bus.in_data};

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_acc_en    = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = (bus.count_in != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_acc_en = 1'b1;
                    if (r_rem == CNT_W'(1)) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_rem   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_acc   <= '0;
                r_carry <= 1'b0;
                r_rem   <= bus.count_in;
            end else if (w_acc_en) begin
                r_acc   <= w_sum;
                r_carry <= r_carry | w_cout;
                r_rem   <= r_rem - CNT_W'(1);
            end
        end
    end

    // Sum/carry stay visible after the result is taken; only a new start clears them.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_acc;
    assign bus.out_carry = r_carry;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_operand_accumulator.sv
// Directed and randomized bursts against an arithmetic reference of the burst sum.
module tb_operand_accumulator;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    operand_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    operand_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned running sum modulo 2**WIDTH, carry if any partial sum overflowed.
    function automatic void model(input logic [WIDTH-1:0] ops[$],
                                  output logic [WIDTH-1:0] s, output logic c);
        longint unsigned acc;
        acc = 0;
        c   = 1'b0;
        foreach (ops[i]) begin
            acc = acc + ops[i];
            if (acc >= (64'd1 << WIDTH)) begin
                c   = 1'b1;
                acc = acc - (64'd1 << WIDTH);
            end
        end
        s = acc[WIDTH-1:0];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_sum"},   bus.out_sum,   0);
        check({tag, "_out_carry"}, bus.out_carry, 0);
        check({tag, "_busy"},      bus.busy,      0);
    endtask

    // Runs one full burst from IDLE. gap<0 -> random gaps; hold<0 -> random out_ready delay.
    task automatic burst(input string tag, input logic [WIDTH-1:0] ops[$],
                         input int gap, input int hold);
        logic [WIDTH-1:0] exp_s;
        logic             exp_c;
        int               g;
        int               h;
        model(ops, exp_s, exp_c);
        bus.start    = 1'b1;
        bus.count_in = CNT_W'(ops.size());
        tick();
        bus.start    = 1'b0;
        bus.count_in = CNT_W'($urandom);
        check({tag, "_busy_after_start"}, bus.busy, 1);
        foreach (ops[i]) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
            for (int k = 0; k < g; k++) begin
                bus.in_valid = 1'b0;
                bus.in_data  = WIDTH'($urandom);
                bus.start    = $urandom_range(0, 1) != 0;
                tick();
            end
            check({tag, "_in_ready"},  bus.in_ready,  1);
            check({tag, "_no_result"}, bus.out_valid, 0);
            bus.start    = $urandom_range(0, 1) != 0;
            bus.in_valid = 1'b1;
            bus.in_data  = ops[i];
            tick();
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check({tag, "_out_valid"}, bus.out_valid, 1);
        h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
        for (int k = 0; k < h; k++) begin
            bus.out_ready = 1'b0;
            bus.start     = $urandom_range(0, 1) != 0;
            bus.in_valid  = $urandom_range(0, 1) != 0;
            bus.in_data   = WIDTH'($urandom);
            tick();
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_sum"},   bus.out_sum,   exp_s);
            check({tag, "_hold_carry"}, bus.out_carry, exp_c);
            check({tag, "_hold_inrdy"}, bus.in_ready,  0);
        end
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, "_sum"},      bus.out_sum,   exp_s);
        check({tag, "_carry"},    bus.out_carry, exp_c);
        check({tag, "_done_rdy"}, bus.in_ready,  0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_idle_valid"}, bus.out_valid, 0);
        check({tag, "_idle_busy"},  bus.busy,      0);
        check({tag, "_kept_sum"},   bus.out_sum,   exp_s);
        // Operand offered in IDLE must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'($urandom);
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_idle_inrdy"}, bus.in_ready,  0);
        check({tag, "_idle_sum"},   bus.out_sum,   exp_s);
        check({tag, "_idle_carry"}, bus.out_carry, exp_c);
    endtask

    initial begin
        logic [WIDTH-1:0] q[$];
        int               n;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.count_in  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        q = '{16'h0001, 16'h0002, 16'h0003};
        burst("t1_simple", q, 0, 0);
        q = '{16'hFFFF, 16'h0001, 16'h0005};
        burst("t2_carry", q, 0, 1);
        q = '{16'h1234, 16'h1111};
        burst("t3_gaps_hold", q, 3, 5);
        q = {};
        burst("t4_empty", q, 0, 2);

        // Reset in the middle of a burst discards everything.
        bus.start    = 1'b1;
        bus.count_in = 4'd4;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h8000;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("t5_partial_carry", bus.out_carry, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("t5_midreset");
        q = '{16'h0007};
        burst("t5_after", q, 0, 0);

        for (int t = 0; t < 25; t++) begin
            q = {};
            n = int'($urandom_range(0, (1 << CNT_W) - 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) != 0) q.push_back(WIDTH'($urandom_range(16'hC000, 16'hFFFF)));
                else                           q.push_back(WIDTH'($urandom_range(0, 16'h0FFF)));
            end
            burst($sformatf("rand%0d", t), q, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
